// File: rtl/dsp_fir_sequencer.sv
// FIR sequencer that time-multiplexes one external DSP slice as a MAC: one tap per cycle,
// then drains the slice pipeline and returns the captured P word through a valid/ready port.
module dsp_fir_sequencer #(
    parameter int TAPS    = 8,
    parameter int MUL_LAT = 3
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    COEF_WE,
    input  logic [$clog2(TAPS)-1:0] COEF_ADDR,
    input  logic signed [17:0]      COEF_DATA,
    input  logic                    CLR_HIST,
    input  logic                    S_VALID,
    output logic                    S_READY,
    input  logic signed [17:0]      S_DATA,
    output logic                    Y_VALID,
    input  logic                    Y_READY,
    output logic [47:0]             Y_DATA,
    output logic signed [17:0]      A,
    output logic signed [17:0]      B,
    output logic [7:0]              OPMODE,
    output logic                    CE_DSP,
    input  logic [47:0]             P_IN
);

    localparam int AW     = $clog2(TAPS);
    localparam int DATA_W = 18;
    localparam int COEF_W = 18;
    localparam int DW     = $clog2(MUL_LAT + 2);

    localparam logic [7:0] OP_FIRST = 8'h01;
    localparam logic [7:0] OP_ACCUM = 8'h09;

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

    state_t                   state;
    logic signed [DATA_W-1:0] hist [TAPS];
    logic signed [COEF_W-1:0] coef [TAPS];
    logic [AW-1:0]            tap;
    logic [DW-1:0]            drain_cnt;
    logic [7:0]               op_p0;
    logic [7:0]               op_pipe [MUL_LAT];
    logic                     accept;

    assign accept = (state == IDLE) && S_VALID && S_READY;

    // Stage p0: all slice-facing outputs are registered, so the slice sees each state one cycle late.
    // DRAIN therefore runs one extra internal cycle so P_IN is sampled after the last product lands.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state     <= IDLE;
            tap       <= '0;
            drain_cnt <= '0;
            S_READY   <= 1'b0;
            Y_VALID   <= 1'b0;
            Y_DATA    <= '0;
            A         <= '0;
            B         <= '0;
            CE_DSP    <= 1'b0;
            op_p0     <= '0;
            for (int k = 0; k < TAPS; k++) begin
                hist[k] <= '0;
                coef[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    S_READY <= 1'b1;
                    A       <= '0;
                    B       <= '0;
                    CE_DSP  <= 1'b0;
                    op_p0   <= '0;
                    if (COEF_WE && (int'(COEF_ADDR) < TAPS))
                        coef[COEF_ADDR] <= COEF_DATA;
                    if (accept) begin
                        // A simultaneous clear wipes the old history before the new sample lands.
                        hist[0] <= S_DATA;
                        for (int k = 1; k < TAPS; k++)
                            hist[k] <= CLR_HIST ? '0 : hist[k-1];
                        tap     <= '0;
                        S_READY <= 1'b0;
                        state   <= MAC;
                    end else if (CLR_HIST) begin
                        for (int k = 0; k < TAPS; k++)
                            hist[k] <= '0;
                    end
                end
                MAC: begin
                    A      <= hist[tap];
                    B      <= coef[tap];
                    CE_DSP <= 1'b1;
                    op_p0  <= (tap == '0) ? OP_FIRST : OP_ACCUM;
                    if (tap == AW'(TAPS - 1)) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        tap <= tap + AW'(1);
                    end
                end
                DRAIN: begin
                    A     <= '0;
                    B     <= '0;
                    op_p0 <= '0;
                    if (drain_cnt == DW'(MUL_LAT + 1)) begin
                        CE_DSP  <= 1'b0;
                        Y_DATA  <= P_IN;
                        Y_VALID <= 1'b1;
                        state   <= OUT;
                    end else begin
                        CE_DSP    <= 1'b1;
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                OUT: begin
                    CE_DSP <= 1'b0;
                    if (Y_READY) begin
                        Y_VALID <= 1'b0;
                        S_READY <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    S_READY <= 1'b0;
                    Y_VALID <= 1'b0;
                    CE_DSP  <= 1'b0;
                    op_p0   <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Stages p1..pN: opcode follows its operands through the slice's A/B/M registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int k = 0; k < MUL_LAT; k++)
                op_pipe[k] <= '0;
        end else begin
            op_pipe[0] <= op_p0;
            for (int k = 1; k < MUL_LAT; k++)
                op_pipe[k] <= op_pipe[k-1];
        end
    end

    assign OPMODE = op_pipe[MUL_LAT-1];

endmodule

// File: tb/tb_dsp_fir_sequencer.sv
// Bench for dsp_fir_sequencer: behavioural DSP slice plus a scoreboard of expected FIR results.
module tb_dsp_fir_sequencer;

    localparam int TAPS    = 8;
    localparam int MUL_LAT = 3;
    localparam int AW      = $clog2(TAPS);
    localparam int LAT     = TAPS + MUL_LAT + 2;

    logic                CLK;
    logic                RSTN;
    logic                COEF_WE;
    logic [AW-1:0]       COEF_ADDR;
    logic signed [17:0]  COEF_DATA;
    logic                CLR_HIST;
    logic                S_VALID;
    logic                S_READY;
    logic signed [17:0]  S_DATA;
    logic                Y_VALID;
    logic                Y_READY;
    logic [47:0]         Y_DATA;
    logic signed [17:0]  A;
    logic signed [17:0]  B;
    logic [7:0]          OPMODE;
    logic                CE_DSP;
    logic [47:0]         P_IN;

    dsp_fir_sequencer #(.TAPS(TAPS), .MUL_LAT(MUL_LAT)) dut (
        .CLK(CLK), .RSTN(RSTN), .COEF_WE(COEF_WE), .COEF_ADDR(COEF_ADDR),
        .COEF_DATA(COEF_DATA), .CLR_HIST(CLR_HIST), .S_VALID(S_VALID),
        .S_READY(S_READY), .S_DATA(S_DATA), .Y_VALID(Y_VALID), .Y_READY(Y_READY),
        .Y_DATA(Y_DATA), .A(A), .B(B), .OPMODE(OPMODE), .CE_DSP(CE_DSP), .P_IN(P_IN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural slice: A0/B0, A1/B1, M registers, then P with X=M (op[1:0]=01) and Z=P (op[3]).
    logic signed [17:0] a_p0, b_p0, a_p1, b_p1;
    logic signed [35:0] m_p2;
    logic [47:0]        p_reg;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            a_p0 <= '0; b_p0 <= '0; a_p1 <= '0; b_p1 <= '0; m_p2 <= '0; p_reg <= '0;
        end else if (CE_DSP) begin
            a_p0  <= A;
            b_p0  <= B;
            a_p1  <= a_p0;
            b_p1  <= b_p0;
            m_p2  <= a_p1 * b_p1;
            p_reg <= (OPMODE[3] ? p_reg : 48'd0) +
                     ((OPMODE[1:0] == 2'b01) ? {{12{m_p2[35]}}, m_p2} : 48'd0);
        end
    end
    assign P_IN = p_reg;

    typedef struct {
        logic [47:0] y;
        int          acc_cyc;
    } exp_t;

    exp_t               sb[$];
    logic signed [17:0] h_m [TAPS];
    logic signed [17:0] c_m [TAPS];
    int                 total = 0;
    int                 bad = 0;
    int                 cyc = 0;
    int                 rise_cnt = 0;
    logic               yv_prev = 1'b0;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [47:0] fir_ref();
        logic signed [47:0] acc;
        acc = '0;
        for (int k = 0; k < TAPS; k++)
            acc = acc + 48'(h_m[k]) * 48'(c_m[k]);
        return acc;
    endfunction

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard: push on accept, check latency on Y_VALID rise, pop and compare on handshake.
    always @(negedge CLK) begin
        if (RSTN) begin
            if (S_VALID && S_READY) begin
                for (int k = TAPS - 1; k > 0; k--)
                    h_m[k] = CLR_HIST ? 18'sd0 : h_m[k-1];
                h_m[0] = S_DATA;
                sb.push_back('{y: fir_ref(), acc_cyc: cyc + 1});
            end
            if (Y_VALID && !yv_prev) begin
                rise_cnt++;
                if (sb.size() > 0)
                    check_eq("latency", 48'(cyc - sb[0].acc_cyc), 48'(LAT));
            end
            if (Y_VALID && Y_READY) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_y", 48'(sb.size()), 48'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("y_data", Y_DATA, e.y);
                end
            end
        end
        yv_prev = Y_VALID;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_coef(input int addr, input int data, input bit taken);
        COEF_WE   = 1'b1;
        COEF_ADDR = AW'(addr);
        COEF_DATA = 18'(data);
        tick();
        COEF_WE = 1'b0;
        if (taken) c_m[addr] = 18'(data);
    endtask

    task automatic send_sample(input int data, input bit clr);
        bit ok;
        ok       = 1'b0;
        S_VALID  = 1'b1;
        S_DATA   = 18'(data);
        CLR_HIST = clr;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge CLK);
            if (S_READY) ok = 1'b1;
        end
        if (!ok) check_eq("accept_timeout", 48'(S_READY), 48'd1);
        tick();
        S_VALID  = 1'b0;
        CLR_HIST = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        check_eq("drain_timeout", 48'(sb.size()), 48'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, total=%0d", total);
        $fatal(1, "watchdog");
    end

    initial begin
        int  hold_bad;
        int  r0;
        logic [7:0] op_want;
        RSTN = 1'b0; COEF_WE = 1'b0; COEF_ADDR = '0; COEF_DATA = '0; CLR_HIST = 1'b0;
        S_VALID = 1'b0; S_DATA = '0; Y_READY = 1'b0;
        for (int k = 0; k < TAPS; k++) begin
            h_m[k] = '0;
            c_m[k] = '0;
        end

        // Reset state and first idle cycle
        repeat (3) @(negedge CLK);
        check_eq("rst_ctrl", {45'd0, S_READY, Y_VALID, CE_DSP}, 48'd0);
        check_eq("rst_ab_op", {4'd0, OPMODE, A, B}, 48'd0);
        check_eq("rst_ydata", Y_DATA, 48'd0);
        tick();
        RSTN = 1'b1;
        tick();
        check_eq("idle_ready", 48'(S_READY), 48'd1);
        check_eq("idle_opmode", 48'(OPMODE), 48'd0);
        check_eq("idle_ce", 48'(CE_DSP), 48'd0);

        // Impulse response with coef 1..8
        Y_READY = 1'b1;
        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1, 1'b1);
        send_sample(1, 1'b0);
        for (int k = 1; k < TAPS; k++) send_sample(0, 1'b0);
        wait_drain();

        // Constant input, with slice-port trace of the first transaction
        for (int k = 0; k < TAPS; k++) write_coef(k, 3, 1'b1);
        send_sample(5, 1'b0);
        for (int i = 0; i <= LAT - 1; i++) begin
            @(negedge CLK);
            if (i == MUL_LAT + 1) op_want = 8'h01;
            else if (i > MUL_LAT + 1 && i <= MUL_LAT + TAPS) op_want = 8'h09;
            else op_want = 8'h00;
            check_eq($sformatf("opmode_c%0d", i), 48'(OPMODE), 48'(op_want));
            check_eq($sformatf("ce_c%0d", i), 48'(CE_DSP), 48'((i >= 1 && i <= LAT - 1) ? 1 : 0));
            if (i == 1) begin
                check_eq("mac0_a", 48'(A), 48'd5);
                check_eq("mac0_b", 48'(B), 48'd3);
            end
        end
        tick();
        for (int k = 1; k < TAPS; k++) send_sample(5, 1'b0);
        wait_drain();
        check_eq("hist_all5", fir_ref(), 48'd120);

        // Backpressure: result held, S_VALID ignored
        Y_READY = 1'b0;
        send_sample(2, 1'b0);
        for (int i = 0; i < 40 && !Y_VALID; i++) @(negedge CLK);
        check_eq("hold_vld_up", 48'(Y_VALID), 48'd1);
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            S_VALID = (i % 2 == 0);
            S_DATA  = 18'(100 + i);
            @(negedge CLK);
            if (!Y_VALID || S_READY || sb.size() != 1 || Y_DATA !== sb[0].y) hold_bad++;
        end
        check_eq("hold_bad_cycles", 48'(hold_bad), 48'd0);
        tick();
        S_VALID = 1'b0;
        Y_READY = 1'b1;
        tick();
        check_eq("after_hs_vld", 48'(Y_VALID), 48'd0);
        check_eq("after_hs_rdy", 48'(S_READY), 48'd1);
        check_eq("after_hs_sb", 48'(sb.size()), 48'd0);

        // Coefficient write during MAC is ignored; clear + sample
        send_sample(4, 1'b0);
        write_coef(0, 99, 1'b0);
        wait_drain();
        write_coef(0, 2, 1'b1);
        send_sample(7, 1'b1);
        wait_drain();
        check_eq("clr_ref", fir_ref(), 48'd14);

        // Reset during DRAIN aborts the transaction and clears the bank
        send_sample(3, 1'b0);
        repeat (TAPS + 2) @(posedge CLK);
        #1;
        RSTN = 1'b0;
        #1;
        check_eq("abort_ctrl", {45'd0, S_READY, Y_VALID, CE_DSP}, 48'd0);
        check_eq("abort_ab_op", {4'd0, OPMODE, A, B}, 48'd0);
        sb.delete();
        for (int k = 0; k < TAPS; k++) begin
            h_m[k] = '0;
            c_m[k] = '0;
        end
        r0 = rise_cnt;
        repeat (2) tick();
        RSTN = 1'b1;
        repeat (20) tick();
        check_eq("abort_no_valid", 48'(rise_cnt), 48'(r0));
        check_eq("abort_idle_ready", 48'(S_READY), 48'd1);
        send_sample(1, 1'b0);
        for (int k = 1; k < TAPS; k++) send_sample(0, 1'b0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
